// File: rtl/round_timer_pkg.sv
// Shared constants for the round countdown timer.
// Key codes, FSM state encoding and the decoded-key bundle.
package round_timer_pkg;

    localparam logic [7:0] KEY_START     = 8'h16;
    localparam logic [7:0] KEY_PAUSE     = 8'h15;
    localparam logic [7:0] KEY_CLEAR     = 8'h0C;
    localparam logic [7:0] KEY_DIGIT_MAX = 8'h09;

    localparam logic [1:0] ST_ENTRY = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic digit;
        logic start;
        logic pause;
        logic clear;
    } key_t;

endpackage

// File: rtl/bcd4_down.sv
// Four BCD digit registers with clear, left-shift entry and BCD decrement.
// Priority: clear, then decrement, then shift.
module bcd4_down (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       clear,
    input  logic       shift_en,
    input  logic [3:0] shift_digit,
    input  logic       dec,
    output logic [3:0] bcd3,
    output logic [3:0] bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic       zero,
    output logic       is_one
);

    logic [3:0][3:0] dig_q;
    logic [3:0][3:0] dig_d;
    logic            brw;

    always_comb begin
        dig_d = dig_q;
        brw   = 1'b1;
        if (clear) begin
            dig_d = '0;
        end else if (dec) begin
            // ripple borrow: a zero digit wraps to 9 and passes the borrow up
            for (int i = 0; i < 4; i++) begin
                if (brw) begin
                    if (dig_q[i] == 4'd0) begin
                        dig_d[i] = 4'd9;
                    end else begin
                        dig_d[i] = dig_q[i] - 4'd1;
                        brw      = 1'b0;
                    end
                end
            end
        end else if (shift_en) begin
            dig_d = {dig_q[2:0], shift_digit};
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            dig_q <= '0;
        end else begin
            dig_q <= dig_d;
        end
    end

    assign bcd3   = dig_q[3];
    assign bcd2   = dig_q[2];
    assign bcd1   = dig_q[1];
    assign bcd0   = dig_q[0];
    assign zero   = (dig_q == 16'h0000);
    assign is_one = (dig_q == 16'h0001);

endmodule

// File: rtl/round_timer_ctrl.sv
// Game round countdown sequencer: key entry, start/pause/clear FSM,
// one-second prescaler and binary readout of the BCD digits.
module round_timer_ctrl
    import round_timer_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int KEY_W    = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             ready,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_code,
    output logic [3:0]       bcd3,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd0,
    output logic [13:0]      remaining,
    output logic             running,
    output logic             paused,
    output logic             done,
    output logic             timeout
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick;
    logic          timeout_d;
    logic          clr;
    logic          shift_en;
    logic          dec;
    logic          zero;
    logic          is_one;
    key_t          key;

    always_comb begin
        key       = '0;
        key.digit = key_valid && (key_code <= KEY_W'(KEY_DIGIT_MAX));
        key.start = key_valid && (key_code == KEY_W'(KEY_START));
        key.pause = key_valid && (key_code == KEY_W'(KEY_PAUSE));
        key.clear = key_valid && (key_code == KEY_W'(KEY_CLEAR));
    end

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        timeout_d = 1'b0;
        clr       = 1'b0;
        shift_en  = 1'b0;
        dec       = 1'b0;
        if (!ready) begin
            state_d = ST_ENTRY;
            presc_d = '0;
            clr     = 1'b1;
        end else begin
            unique case (state_q)
                ST_ENTRY: begin
                    if (key.clear) begin
                        clr = 1'b1;
                    end else if (key.digit) begin
                        shift_en = 1'b1;
                    end else if (key.start && !zero) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                ST_RUN: begin
                    // the count advances even on the cycle a PAUSE lands
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    dec     = tick;
                    if (key.clear) begin
                        state_d = ST_ENTRY;
                        clr     = 1'b1;
                    end else if (tick && is_one) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b1;
                    end else if (key.pause) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (key.clear) begin
                        state_d = ST_ENTRY;
                        clr     = 1'b1;
                    end else if (key.start || key.pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (key.start || key.clear) begin
                        state_d = ST_ENTRY;
                        clr     = 1'b1;
                    end
                end
                default: state_d = ST_ENTRY;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= ST_ENTRY;
            presc_q <= '0;
            running <= 1'b0;
            paused  <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            running <= (state_d == ST_RUN);
            paused  <= (state_d == ST_PAUSE);
            done    <= (state_d == ST_DONE);
            timeout <= timeout_d;
        end
    end

    bcd4_down u_digits (
        .clk_in      (clk_in),
        .rst         (rst),
        .clear       (clr),
        .shift_en    (shift_en),
        .shift_digit (key_code[3:0]),
        .dec         (dec),
        .bcd3        (bcd3),
        .bcd2        (bcd2),
        .bcd1        (bcd1),
        .bcd0        (bcd0),
        .zero        (zero),
        .is_one      (is_one)
    );

    assign remaining = 14'(bcd3) * 14'd1000 + 14'(bcd2) * 14'd100
                     + 14'(bcd1) * 14'd10 + 14'(bcd0);

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Scoreboard bench for round_timer_ctrl with TICK_DIV=4.
// Stimulus schedules expected snapshots; a negedge monitor compares them.
module tb_round_timer_ctrl;
    import round_timer_pkg::*;

    logic        clk_in    = 1'b0;
    logic        rst       = 1'b1;
    logic        ready     = 1'b1;
    logic        key_valid = 1'b0;
    logic [7:0]  key_code  = 8'h00;
    logic [3:0]  bcd3, bcd2, bcd1, bcd0;
    logic [13:0] remaining;
    logic        running, paused, done, timeout;

    round_timer_ctrl #(.TICK_DIV(4), .KEY_W(8)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .ready     (ready),
        .key_valid (key_valid),
        .key_code  (key_code),
        .bcd3      (bcd3),
        .bcd2      (bcd2),
        .bcd1      (bcd1),
        .bcd0      (bcd0),
        .remaining (remaining),
        .running   (running),
        .paused    (paused),
        .done      (done),
        .timeout   (timeout)
    );

    always #5 clk_in = ~clk_in;

    // flags = {running, paused, done, timeout}
    localparam logic [3:0] F_IDLE = 4'b0000;
    localparam logic [3:0] F_RUN  = 4'b1000;
    localparam logic [3:0] F_PAU  = 4'b0100;
    localparam logic [3:0] F_DONE = 4'b0010;
    localparam logic [3:0] F_TO   = 4'b0011;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    int         q_at[$];
    logic [15:0] q_dig[$];
    logic [3:0]  q_flg[$];
    string       q_nm[$];
    int          tq[$];

    int          m_at;
    logic [15:0] m_dig;
    logic [3:0]  m_flg;
    string       m_nm;
    int          t_exp;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic int rem_of(input logic [15:0] d);
        return 1000 * int'(d[15:12]) + 100 * int'(d[11:8])
             + 10 * int'(d[7:4]) + int'(d[3:0]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, got, want);
    endtask

    task automatic expect_at(input int n, input logic [15:0] d,
                             input logic [3:0] f, input string nm);
        q_at.push_back(cyc + n);
        q_dig.push_back(d);
        q_flg.push_back(f);
        q_nm.push_back(nm);
    endtask

    always @(negedge clk_in) begin
        while (q_at.size() > 0 && q_at[0] <= cyc) begin
            m_at  = q_at.pop_front();
            m_dig = q_dig.pop_front();
            m_flg = q_flg.pop_front();
            m_nm  = q_nm.pop_front();
            chk({m_nm, ".digits"}, 32'({bcd3, bcd2, bcd1, bcd0}), 32'(m_dig));
            chk({m_nm, ".flags"}, 32'({running, paused, done, timeout}),
                32'(m_flg));
            chk({m_nm, ".remaining"}, 32'(remaining), 32'(rem_of(m_dig)));
        end
        if (timeout === 1'b1) begin
            if (tq.size() > 0) begin
                t_exp = tq.pop_front();
                chk("timeout_cycle", 32'(cyc), 32'(t_exp));
            end else begin
                chk("timeout_spurious", 32'(timeout), 32'(0));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic press(input logic [7:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk_in);
        #1;
        key_valid = 1'b0;
        key_code  = 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        rst = 1'b0;
        expect_at(0, 16'h0000, F_IDLE, "reset");
        step(1);

        // entry, shift-out, ignored codes, clear, start at zero
        press(8'h01); press(8'h02); press(8'h03); press(8'h04); press(8'h05);
        expect_at(0, 16'h2345, F_IDLE, "entry_shift");
        press(8'h0A); press(KEY_PAUSE);
        expect_at(0, 16'h2345, F_IDLE, "entry_ignore");
        press(KEY_CLEAR);
        expect_at(0, 16'h0000, F_IDLE, "entry_clear");
        press(KEY_START);
        expect_at(0, 16'h0000, F_IDLE, "start_zero");
        expect_at(2, 16'h0000, F_IDLE, "start_zero_hold");
        step(2);

        // borrow across two digits
        press(8'h00); press(8'h01); press(8'h00); press(8'h00);
        expect_at(0, 16'h0100, F_IDLE, "b_entry");
        press(KEY_START);
        expect_at(0, 16'h0100, F_RUN, "b_start");
        expect_at(3, 16'h0100, F_RUN, "b_pre");
        expect_at(4, 16'h0099, F_RUN, "b_tick1");
        expect_at(7, 16'h0099, F_RUN, "b_hold");
        expect_at(8, 16'h0098, F_RUN, "b_tick2");
        press(8'h03);
        press(KEY_START);
        step(6);
        press(KEY_CLEAR);
        expect_at(0, 16'h0000, F_IDLE, "b_clear");

        press(8'h01); press(8'h00); press(8'h00); press(8'h00);
        press(KEY_START);
        expect_at(3, 16'h1000, F_RUN, "b1000_pre");
        expect_at(4, 16'h0999, F_RUN, "b1000_tick");
        step(4);
        press(KEY_CLEAR);

        // countdown to zero with timeout pulse
        press(8'h02);
        press(KEY_START);
        tq.push_back(cyc + 8);
        expect_at(4, 16'h0001, F_RUN, "to_one");
        expect_at(7, 16'h0001, F_RUN, "to_one_hold");
        expect_at(8, 16'h0000, F_TO, "to_pulse");
        expect_at(9, 16'h0000, F_DONE, "to_done");
        step(9);
        press(8'h01);
        expect_at(0, 16'h0000, F_DONE, "done_ignore");
        press(KEY_START);
        expect_at(0, 16'h0000, F_IDLE, "done_start");

        // pause and resume keep the prescaler position
        press(8'h05);
        press(KEY_START);
        step(1);
        press(KEY_PAUSE);
        expect_at(0, 16'h0005, F_PAU, "p_pause");
        expect_at(20, 16'h0005, F_PAU, "p_frozen");
        step(20);
        press(KEY_PAUSE);
        expect_at(0, 16'h0005, F_RUN, "p_resume");
        expect_at(1, 16'h0005, F_RUN, "p_resume_pre");
        expect_at(2, 16'h0004, F_RUN, "p_tick");
        step(2);
        press(KEY_CLEAR);
        expect_at(0, 16'h0000, F_IDLE, "p_clear");

        // PAUSE on a tick cycle
        press(8'h03);
        press(KEY_START);
        step(3);
        press(KEY_PAUSE);
        expect_at(0, 16'h0002, F_PAU, "c1_pause_tick");
        expect_at(5, 16'h0002, F_PAU, "c1_hold");
        step(5);
        press(KEY_START);
        expect_at(0, 16'h0002, F_RUN, "c1_resume");
        expect_at(3, 16'h0002, F_RUN, "c1_pre");
        expect_at(4, 16'h0001, F_RUN, "c1_tick");
        step(4);
        press(KEY_CLEAR);

        // PAUSE on the tick that reaches zero
        press(8'h01);
        press(KEY_START);
        step(3);
        tq.push_back(cyc + 1);
        press(KEY_PAUSE);
        expect_at(0, 16'h0000, F_TO, "c2_timeout");
        expect_at(1, 16'h0000, F_DONE, "c2_done");
        step(1);
        press(KEY_CLEAR);
        expect_at(0, 16'h0000, F_IDLE, "c2_clear");

        // ready low during RUN
        press(8'h07);
        press(KEY_START);
        step(2);
        ready = 1'b0;
        press(8'h05);
        ready = 1'b1;
        expect_at(0, 16'h0000, F_IDLE, "rdy_force");
        expect_at(6, 16'h0000, F_IDLE, "rdy_hold");
        step(6);

        // asynchronous reset mid-RUN
        press(8'h04); press(8'h02);
        press(KEY_START);
        step(1);
        expect_at(0, 16'h0042, F_RUN, "r_run");
        step(1);
        rst = 1'b1;
        expect_at(0, 16'h0000, F_IDLE, "r_async");
        @(negedge clk_in);
        #1;
        rst = 1'b0;
        expect_at(3, 16'h0000, F_IDLE, "r_after");
        step(4);

        step(3);
        while (q_at.size() > 0) begin
            n_chk++;
            $display("FAIL missed_%s: got no sample want cycle %0d",
                     q_nm[0], q_at[0]);
            void'(q_at.pop_front());
            void'(q_dig.pop_front());
            void'(q_flg.pop_front());
            void'(q_nm.pop_front());
        end
        while (tq.size() > 0) begin
            n_chk++;
            $display("FAIL timeout_missing: got no pulse want cycle %0d", tq[0]);
            void'(tq.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
